// File: rtl/sipo_frame_receiver_pkg.sv
// Shared definitions for the serial-in / parallel-out frame receiver.
//   state_e    : receiver FSM states (IDLE, SHIFT)
//   cnt_width(): width of the bit counter for a given word width
package sipo_frame_receiver_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter must be able to represent 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register for completed words.
// A completed word loads when the register is empty or draining in the
// same cycle; otherwise it is dropped and the sticky overrun flag is set.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : a word completed this cycle
//   word_i      : the completed word
//   ready_i     : consumer accepts when valid_o is also 1
//   clr_err_i   : clears overrun_o (a new overrun in the same cycle wins)
//   data_o      : held word, stable while valid_o=1 and ready_i=0
//   valid_o     : data_o holds an unconsumed word
//   overrun_o   : sticky, a completed word was dropped
module sipo_out_reg
  import sipo_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             accept;

  // Space is available if empty, or if the held word leaves this cycle.
  assign accept = !valid_q || ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q && !clr_err_i;
    if (load_i && accept) begin
      data_d  = word_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (load_i && !accept) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver. Reassembles WIDTH-bit words from a
// serial stream aligned by a frame_start strobe on the first bit, and
// hands them to a one-entry valid/ready output register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   ser_in       : serial data bit, sampled when ser_valid=1
//   ser_valid    : qualifies ser_in and frame_start
//   frame_start  : ser_in is bit 0 of a new frame
//   par_out      : assembled word (stable while par_valid & !par_ready)
//   par_valid    : par_out holds an unconsumed word
//   par_ready    : consumer accept
//   busy         : a frame is partially received
//   bit_cnt      : bits captured in the current frame
//   overrun_err  : sticky, a completed word was dropped
//   resync_err   : sticky, frame_start arrived mid-frame
//   clr_err      : clears both sticky flags (a set in the same cycle wins)
module sipo_frame_receiver
  import sipo_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CNT_W    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun_err,
  output logic             resync_err,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resync_q, resync_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic             word_done;

  // shifted: current bit appended to the partial word.
  // first_bit: a fresh frame holding only bit 0 (no residue from earlier bits).
  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {sr_q[WIDTH-2:0], ser_in};
      first_bit = {{(WIDTH-1){1'b0}}, ser_in};
    end else begin
      shifted   = {ser_in, sr_q[WIDTH-1:1]};
      first_bit = {ser_in, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    resync_d  = resync_q && !clr_err;
    word_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ser_valid && frame_start) begin
          sr_d    = first_bit;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_valid) begin
          if (frame_start) begin
            sr_d     = first_bit;
            cnt_d    = CNT_W'(1);
            resync_d = 1'b1;
          end else begin
            sr_d = shifted;
            if (cnt_q == LAST_IDX) begin
              cnt_d     = '0;
              state_d   = IDLE;
              word_done = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      resync_q <= resync_d;
    end
  end

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (word_done),
    .word_i    (shifted),
    .ready_i   (par_ready),
    .clr_err_i (clr_err),
    .data_o    (par_out),
    .valid_o   (par_valid),
    .overrun_o (overrun_err)
  );

  assign busy       = (state_q == SHIFT);
  assign bit_cnt    = cnt_q;
  assign resync_err = resync_q;

endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Downstream partner of the PISO shift register: consumes its serial bit stream and reassembles fixed-width parallel words.
- Frame alignment comes from a start-of-frame strobe that accompanies the first bit.
- Completed words go to a one-entry output register with a valid/ready handshake, so a new frame can be received while the previous word waits.
- Overrun and resynchronisation errors are reported through sticky flags.

Parameters:
- WIDTH, 4, bits per frame / parallel word width (>=2).
- MSB_FIRST, 1, 1: first serial bit lands in par_out[WIDTH-1]; 0: first bit lands in par_out[0].

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled only in cycles where this is 1.
- frame_start  input  1  qualified by ser_valid; marks ser_in as bit 0 of a new frame.
- par_out  output  WIDTH  assembled word; stable while par_valid=1.
- par_valid  output  1  par_out holds an unconsumed word.
- par_ready  input  1  consumer accepts; a transfer occurs when par_valid and par_ready are both 1.
- busy  output  1  a frame is partially received (state SHIFT).
- bit_cnt  output  clog2(WIDTH+1)  bits captured in the current frame.
- overrun_err  output  1  sticky; a completed word was dropped.
- resync_err  output  1  sticky; frame_start arrived mid-frame.
- clr_err  input  1  clears both sticky flags next cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - par_out=0, par_valid=0, busy=0, bit_cnt=0, overrun_err=0, resync_err=0.
  - State=IDLE; shift register=0.
  - rst dominates every other input, including mid-frame; any partial frame is discarded.
- States: IDLE, SHIFT.
- IDLE:
  - ser_valid & frame_start: capture ser_in as bit 0, bit_cnt=1, go SHIFT.
  - ser_valid without frame_start: bit ignored.
- SHIFT, ser_valid=0: hold all state (gaps allowed between bits).
- SHIFT, ser_valid & !frame_start:
  - Shift in ser_in: left shift for MSB_FIRST=1, right shift otherwise. bit_cnt++.
  - If this is bit WIDTH-1, the word is complete: bit_cnt=0, go IDLE.
- SHIFT, ser_valid & frame_start:
  - Discard the partial frame and set resync_err.
  - Capture ser_in as the new bit 0, bit_cnt=1, stay SHIFT.
- Word completion, evaluated in the cycle the last bit is sampled:
  - Output free (par_valid=0) or draining (par_valid & par_ready): load par_out and set par_valid=1 next cycle. Latency is 1 clk from last-bit sample to par_valid.
  - Output full and not draining: drop the new word, set overrun_err, leave par_out unchanged.
- Handshake:
  - par_valid falls the cycle after a transfer, unless a new word loads in that same cycle (back-to-back; par_valid stays 1).
  - par_out never changes while par_valid=1 and par_ready=0.
- Bit ordering: with MSB_FIRST=1 the serial sequence b0,b1,...,b(W-1) yields par_out = {b0,b1,...,b(W-1)}.
- Back-to-back frames: frame_start is legal in the cycle right after a last bit (state is IDLE by then). No dead cycles are required.
- Sticky errors:
  - Set has priority over clr_err in the same cycle.
  - Flags are not cleared by a completed frame.

Decomposition:
- Shared package: state enum (IDLE, SHIFT), and the bit_cnt width helper constant CNT_W = $clog2(WIDTH+1).
- One natural sub-module: sipo_out_reg, the one-entry valid/ready holding register with load/drop/overrun logic.
- The shifter, bit counter and FSM stay in the top module.

Test Plan:
- WIDTH=4, MSB_FIRST=1: frame_start with bits 1,0,1,1 on consecutive cycles, par_ready=1 -> par_out=4'b1011 and par_valid=1 one clk after the 4th bit, then par_valid=0.
- Same bits with ser_valid deasserted for 3 cycles between bits 2 and 3 -> identical par_out=4'b1011; bit_cnt holds at 2 during the gap.
- par_ready=0; send 1011 then 0110 -> par_out stays 1011 and overrun_err=1. Then par_ready=1, send 1100 -> 1011 transfers, then par_out=1100.
- After 2 bits (1,0), assert frame_start with bits 0,1,1,1 -> resync_err=1 and par_out=4'b0111.
- MSB_FIRST=0: bits 1,0,1,1 -> par_out=4'b1101. Then clr_err=1 -> both error flags read 0.
- rst=1 after bit 3 of a frame, then a full frame 0101 -> all outputs zero after reset; next par_out=4'b0101 with no residue from the aborted frame.
